// File: rtl/ai_core_arith_pkg.sv
// Shared arithmetic types and tree-wide defaults for the multiplier datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ai_core_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_res_state_e;

    localparam int unsigned CSA_RES_W     = 32;
    localparam int unsigned CSA_RES_CHUNK = 8;

    // Counter must stay at least one bit wide even for a single-chunk resolver.
    function automatic int unsigned csa_cnt_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full_adder cells.
// Latency: combinational.
// Backpressure: n/a.
module csa_chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: n/a.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into one W+2-bit binary result, CHUNK bits per cycle.
// Latency: accept edge T, result valid in cycle T+NCHUNK+1; one result per NCHUNK+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready low whenever busy.
module csa_resolver
    import ai_core_arith_pkg::*;
#(
    parameter int unsigned W     = CSA_RES_W,
    parameter int unsigned CHUNK = CSA_RES_CHUNK
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_sum,
    input  logic [W-1:0]   in_carry,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   out_result,
    output logic           busy
);

    localparam int unsigned NCHUNK = W / CHUNK;
    localparam int unsigned CW     = csa_cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((W % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
        $error("csa_resolver: W must be a non-zero multiple of CHUNK");
    end

    csa_res_state_e state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           top_b_q, top_b_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W+1:0]   result_q, result_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             chunk_cout;
    logic             last_chunk;

    assign last_chunk = (cnt_q == LAST);

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // A single adder instance is time-shared across all chunks.
    csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .s    (s_chunk),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            top_b_q  <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            top_b_q  <= top_b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = ADD;
            ADD:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        top_b_d  = top_b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = in_sum;
            b_d     = in_carry << 1;
            top_b_d = in_carry[W-1];
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ADD) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CW'(k)) begin
                    result_d[k*CHUNK +: CHUNK] = s_chunk;
                end
            end
            carry_d = chunk_cout;
            // The carry bit shifted out of in_carry lands at weight 2^W with the final carry-out.
            if (last_chunk) begin
                result_d[W]   = top_b_q ^ chunk_cout;
                result_d[W+1] = top_b_q & chunk_cout;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        out_result = result_q;
    end

endmodule
